// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared state encoding and select constants for the 2:1
//                round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter state, 2-bit encoding with explicit values
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2
    } state_t;

    // Mux select values
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    // Encoding of which requester finished its grant most recently
    localparam logic SERVED_1 = 1'b0;
    localparam logic SERVED_2 = 1'b1;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_rr_2to1_mux2_w.sv
`default_nettype none
// ============================================================================
//  Module      : mux2_w
//  Description : WIDTH-bit 2:1 combinational select (sel=0 -> in1, 1 -> in2).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2_w
    import arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // Plain select; feeds the output register in the arbiter
    assign out = (sel == SEL_IN2) ? in2 : in1;

endmodule : mux2_w
`default_nettype wire

// File: rtl/arb_rr_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr_2to1
//  Description : Round-robin arbiter sharing one registered WIDTH-bit output
//                channel between two requesters. Grants persist across a
//                burst and are capped at MAX_HOLD beats while the other side
//                waits. Output uses a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_2to1
    import arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in2,
    input  logic             out_ready,
    output logic             gnt1,
    output logic             gnt2,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out
);

    localparam int                CNT_W       = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_last_served;
    logic               w_last_nxt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out;

    logic               w_can_load;
    logic               w_beat1;
    logic               w_beat2;
    logic               w_beat;
    logic [WIDTH-1:0]   w_mux_out;

    // Grant and select are pure decodes of the registered state
    assign gnt1      = (r_state == ST_GRANT1);
    assign gnt2      = (r_state == ST_GRANT2);
    assign sel       = (r_state == ST_GRANT2) ? SEL_IN2 : SEL_IN1;
    assign out_valid = r_out_valid;
    assign out       = r_out;

    // A beat moves only when the output slot is empty or being drained
    assign w_can_load = ~r_out_valid | out_ready;
    assign w_beat1    = gnt1 & req1 & w_can_load;
    assign w_beat2    = gnt2 & req2 & w_can_load;
    assign w_beat     = w_beat1 | w_beat2;

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in1 (in1),
        .in2 (in2),
        .sel (sel),
        .out (w_mux_out)
    );

    // State, burst count and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_count       <= C_CNT_ZERO;
            r_last_served <= SERVED_2;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_last_served <= w_last_nxt;
        end
    end

    // Next-state: pick owner from IDLE, release on req drop, hand over at the hold cap
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_last_nxt  = r_last_served;
        case (r_state)
            ST_IDLE: begin
                if (req1 && !req2) begin
                    w_state_nxt = ST_GRANT1;
                end else if (req2 && !req1) begin
                    w_state_nxt = ST_GRANT2;
                end else if (req1 && req2) begin
                    w_state_nxt = (r_last_served == SERVED_2) ? ST_GRANT1 : ST_GRANT2;
                end
            end
            ST_GRANT1: begin
                if (!req1) begin
                    w_state_nxt = req2 ? ST_GRANT2 : ST_IDLE;
                    w_last_nxt  = SERVED_1;
                    w_count_nxt = C_CNT_ZERO;
                end else if (w_beat1) begin
                    if (r_count == C_CNT_LAST) begin
                        w_count_nxt = C_CNT_ZERO;
                        if (req2) begin
                            w_state_nxt = ST_GRANT2;
                            w_last_nxt  = SERVED_1;
                        end
                    end else begin
                        w_count_nxt = r_count + C_CNT_ONE;
                    end
                end
            end
            ST_GRANT2: begin
                if (!req2) begin
                    w_state_nxt = req1 ? ST_GRANT1 : ST_IDLE;
                    w_last_nxt  = SERVED_2;
                    w_count_nxt = C_CNT_ZERO;
                end else if (w_beat2) begin
                    if (r_count == C_CNT_LAST) begin
                        w_count_nxt = C_CNT_ZERO;
                        if (req1) begin
                            w_state_nxt = ST_GRANT1;
                            w_last_nxt  = SERVED_2;
                        end
                    end else begin
                        w_count_nxt = r_count + C_CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = C_CNT_ZERO;
            end
        endcase
    end

    // Output stage: capture on a beat, drop valid once drained with nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_beat) begin
            r_out       <= w_mux_out;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule : arb_rr_2to1
`default_nettype wire

// File: tb/tb_arb_rr_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_rr_2to1
//  Description : Directed self-checking bench for arb_rr_2to1
//                (WIDTH=8, MAX_HOLD=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_rr_2to1;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst_n;
    logic             req1;
    logic [WIDTH-1:0] in1;
    logic             req2;
    logic [WIDTH-1:0] in2;
    logic             out_ready;
    logic             gnt1;
    logic             gnt2;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out;

    int n_checks;
    int n_errors;

    arb_rr_2to1 #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req1      (req1),
        .in1       (in1),
        .req2      (req2),
        .in2       (in2),
        .out_ready (out_ready),
        .gnt1      (gnt1),
        .gnt2      (gnt2),
        .sel       (sel),
        .out_valid (out_valid),
        .out       (out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        check_eq({tag, "_gnt2"}, 32'(gnt2), 32'd0);
        check_eq({tag, "_sel"},  32'(sel),  32'd0);
        check_eq({tag, "_vld"},  32'(out_valid), 32'd0);
        check_eq({tag, "_out"},  32'(out),  32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req1      = 1'b0;
        req2      = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;

        // ---------------- power-on reset ----------------
        #3;
        check_all_zero("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("por_idle");

        // ---------------- fairness: both requesting ----------------
        req1 = 1'b1; in1 = 8'hA1;
        req2 = 1'b1; in2 = 8'hB2;
        tick();
        check_eq("fair_first_gnt1", 32'(gnt1), 32'd1);
        check_eq("fair_first_gnt2", 32'(gnt2), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq($sformatf("fair_out_%0d", i), 32'(out),
                     ((i / 4) % 2 == 0) ? 32'hA1 : 32'hB2);
            check_eq($sformatf("fair_vld_%0d", i), 32'(out_valid), 32'd1);
        end

        // ---------------- asynchronous reset mid-traffic ----------------
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_all_zero("postrst");

        // ---------------- tie from IDLE after reset ----------------
        req1 = 1'b1; in1 = 8'h11;
        req2 = 1'b1; in2 = 8'h22;
        tick();
        check_eq("tie_gnt1", 32'(gnt1), 32'd1);
        check_eq("tie_gnt2", 32'(gnt2), 32'd0);
        tick();
        check_eq("tie_out1", 32'(out), 32'h11);
        check_eq("tie_vld1", 32'(out_valid), 32'd1);
        req1 = 1'b0;
        tick();
        check_eq("tie_sw_gnt2", 32'(gnt2), 32'd1);
        check_eq("tie_sw_sel",  32'(sel),  32'd1);
        check_eq("tie_sw_vld",  32'(out_valid), 32'd0);
        tick();
        check_eq("tie_out2", 32'(out), 32'h22);
        check_eq("tie_vld2", 32'(out_valid), 32'd1);
        req2 = 1'b0;
        tick();
        check_eq("tie_idle_gnt2", 32'(gnt2), 32'd0);
        check_eq("tie_idle_vld",  32'(out_valid), 32'd0);

        // ---------------- single requester latency ----------------
        req1 = 1'b1; in1 = 8'hA5;
        tick();
        check_eq("single_gnt1", 32'(gnt1), 32'd1);
        check_eq("single_sel0", 32'(sel), 32'd0);
        check_eq("single_vld0", 32'(out_valid), 32'd0);
        tick();
        check_eq("single_out",  32'(out), 32'hA5);
        check_eq("single_vld1", 32'(out_valid), 32'd1);
        check_eq("single_sel1", 32'(sel), 32'd0);
        req1 = 1'b0;
        tick();
        check_eq("single_rel_gnt1", 32'(gnt1), 32'd0);
        check_eq("single_rel_vld",  32'(out_valid), 32'd0);

        // ---------------- backpressure inside a GRANT1 burst ----------------
        req1 = 1'b1; in1 = 8'hC0;
        tick();
        check_eq("bp_gnt1", 32'(gnt1), 32'd1);
        tick();
        check_eq("bp_out0", 32'(out), 32'hC0);
        out_ready = 1'b0;
        in1 = 8'hC1;
        req2 = 1'b1; in2 = 8'hD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("bp_hold_out_%0d", i),  32'(out), 32'hC0);
            check_eq($sformatf("bp_hold_vld_%0d", i),  32'(out_valid), 32'd1);
            check_eq($sformatf("bp_hold_gnt1_%0d", i), 32'(gnt1), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_resume_out1", 32'(out), 32'hC1);
        check_eq("bp_resume_gnt1", 32'(gnt1), 32'd1);
        tick();
        check_eq("bp_resume_out2", 32'(out), 32'hC1);
        check_eq("bp_resume2_gnt1", 32'(gnt1), 32'd1);
        tick();
        check_eq("bp_resume_out3", 32'(out), 32'hC1);
        check_eq("bp_handover_gnt2", 32'(gnt2), 32'd1);
        tick();
        check_eq("bp_other_out", 32'(out), 32'hD0);
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
        check_eq("bp_idle_gnt2", 32'(gnt2), 32'd0);

        // ---------------- solo hold on requester 2 ----------------
        req2 = 1'b1;
        tick();
        check_eq("solo_gnt2", 32'(gnt2), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in2 = 8'(8'h50 + i);
            tick();
            check_eq($sformatf("solo_out_%0d", i),  32'(out), 32'(8'h50 + i));
            check_eq($sformatf("solo_vld_%0d", i),  32'(out_valid), 32'd1);
            check_eq($sformatf("solo_gnt2_%0d", i), 32'(gnt2), 32'd1);
        end
        req2 = 1'b0;
        tick();
        check_eq("solo_rel_gnt2", 32'(gnt2), 32'd0);
        check_eq("solo_rel_vld",  32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_arb_rr_2to1
`default_nettype wire
